sync_frame_tx: RTL and testbench
================================

SYNC_FRAME_TX -- requirements
Module: sync_frame_tx

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits (legal range 1..32).
REQ-002 Parameter GAP_LEN, default 2, count of guard-zero bits after each payload (legal range 1..15).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  request to send one frame; sampled only when ready=1.
REQ-006 data  input  DATA_W  payload; captured on the accepting edge.
REQ-007 ready  output  1  high only in IDLE; start&ready at a rising edge = acceptance.
REQ-008 out  output  1  serial bit stream, registered, one bit per clk.
REQ-009 busy  output  1  high while a frame (preamble, payload or gap) is on out.
REQ-010 done  output  1  one-cycle pulse marking frame completion.

Function
REQ-011 Frame on out SHALL be: preamble 1,1,0,1,1; then data MSB-first; then GAP_LEN zeros.
REQ-012 Moore FSM, states IDLE, PRE, DATA, GAP; every output SHALL be a function of registered state only.
REQ-013 IDLE: out=0, ready=1, busy=0; acceptance -> PRE, bit counter cleared, data latched into a shift register.
REQ-014 PRE: out = preamble bit[counter]; after 5 cycles -> DATA.
REQ-015 DATA: out = latched MSB, shift left each cycle; after DATA_W cycles -> GAP.
REQ-016 GAP: out=0; after GAP_LEN cycles -> IDLE.
REQ-017 Latency: if acceptance is at edge k, the first preamble bit SHALL appear on out in the cycle following edge k.
REQ-018 Frame length SHALL be exactly 5+DATA_W+GAP_LEN cycles; ready SHALL be high again in the cycle after edge k+5+DATA_W+GAP_LEN.
REQ-019 done SHALL be high for exactly the first IDLE cycle after GAP; done=0 at all other times.
REQ-020 Back-to-back: start held high SHALL be accepted in that first IDLE cycle; minimum frame period = 6+DATA_W+GAP_LEN cycles.
REQ-021 start while ready=0 SHALL be ignored, not queued; data changes while busy SHALL NOT affect out.
REQ-022 Payload is not escaped; a payload containing 11011 is a known limitation, and the guard zeros are required to restore non-overlapping detector alignment.
REQ-023 Illegal/unused state encodings SHALL return to IDLE on the next edge.

Reset
REQ-024 rst=0 SHALL asynchronously force IDLE, counter=0, shift register=0, out=0, busy=0, done=0; ready=1 while rst=0.
REQ-025 Reset mid-frame SHALL abort the frame with no further preamble or payload bits; the first acceptance after release SHALL start a complete new frame.
REQ-026 Release of rst SHALL be synchronous to clk externally; no start is accepted on the releasing edge unless rst is already high before that edge.

Structure
REQ-027 Shared package sync_frame_pkg SHALL hold PREAMBLE=5'b11011, PRE_LEN=5, and the state encoding constants, for reuse by the matching detector.
REQ-028 Counter width SHALL be sized to cover max(PRE_LEN, DATA_W, GAP_LEN).
REQ-029 One sub-module, frame_piso (parallel-load, left-shift, MSB-out register), is natural; the FSM and counter stay in the top module.

Verification
REQ-030 Single frame: data=8'hA5, start pulsed once -> out = 1,1,0,1,1,1,0,1,0,0,1,0,1,0,0 over 15 cycles; done high in cycle 16.
REQ-031 Back-to-back: start held high, data=8'hFF then 8'h00 -> second preamble begins exactly 16 cycles after the first; ready high for exactly one cycle between frames.
REQ-032 Busy ignore: start pulsed and data changed to 8'h3C during the payload of an 8'hA5 frame -> the 8'hA5 payload is unaltered and no extra frame follows.
REQ-033 Async reset: rst=0 asserted mid-clock during payload bit 3 -> out=0 and busy=0 immediately, before the next edge; after release a new 8'h81 frame completes correctly.
REQ-034 Loopback: 20 random payloads containing no 11011 pattern, fed into a non-overlapping 11011 detector -> exactly 20 detections, each at the last preamble bit.

Source files
------------

// File: rtl/sync_frame_pkg.sv
// Shared framing constants for the sync-word transmitter and its matching detector.
// Holds the preamble pattern, its length and the FSM state encoding.
package sync_frame_pkg;

    localparam logic [4:0] PREAMBLE = 5'b11011;
    localparam int         PRE_LEN  = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Preamble is sent first-bit-first from the MSB of PREAMBLE.
    function automatic logic pre_bit(input logic [2:0] idx);
        return PREAMBLE[3'(PRE_LEN - 1) - idx];
    endfunction

endpackage

// File: rtl/sync_frame_tx_piso.sv
// Parallel-load, left-shift register presenting its MSB as the next payload bit.
module frame_piso #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] sr_r;

    // Payload register: load wins over shift, cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_r <= {W{1'b0}};
        end else if (load) begin
            sr_r <= din;
        end else if (shift) begin
            sr_r <= sr_r << 1;
        end else begin
            sr_r <= sr_r;
        end
    end

    assign msb = sr_r[W-1];

endmodule

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: preamble 11011, payload MSB-first, then GAP_LEN guard zeros.
// All outputs are registered alongside the state so they depend on registered state only.
module sync_frame_tx
    import sync_frame_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int GAP_LEN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              out,
    output logic              busy,
    output logic              done
);

    localparam int CNT_MAX = max3(PRE_LEN, DATA_W, GAP_LEN);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             out_r;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;
    logic             load_s;
    logic             shift_s;
    logic             msb_s;

    // Register strobes: capture on acceptance, advance whenever a payload bit is consumed.
    always_comb begin
        load_s  = 1'b0;
        shift_s = 1'b0;
        case (state_r)
            ST_IDLE: load_s  = start;
            ST_PRE:  shift_s = (cnt_r == CNT_W'(PRE_LEN - 1));
            ST_DATA: shift_s = 1'b1;
            default: begin
                load_s  = 1'b0;
                shift_s = 1'b0;
            end
        endcase
    end

    frame_piso #(.W(DATA_W)) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (load_s),
        .shift (shift_s),
        .din   (data),
        .msb   (msb_s)
    );

    // Frame sequencer; out holds the bit for the cycle after each edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            out_r   <= 1'b0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    cnt_r  <= {CNT_W{1'b0}};
                    if (start) begin
                        state_r <= ST_PRE;
                        out_r   <= pre_bit(3'd0);
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                    end else begin
                        out_r   <= 1'b0;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                ST_PRE: begin
                    if (cnt_r == CNT_W'(PRE_LEN - 1)) begin
                        state_r <= ST_DATA;
                        cnt_r   <= {CNT_W{1'b0}};
                        out_r   <= msb_s;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                        out_r <= pre_bit(cnt_r[2:0] + 3'd1);
                    end
                end
                ST_DATA: begin
                    if (cnt_r == CNT_W'(DATA_W - 1)) begin
                        state_r <= ST_GAP;
                        cnt_r   <= {CNT_W{1'b0}};
                        out_r   <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                        out_r <= msb_s;
                    end
                end
                ST_GAP: begin
                    out_r <= 1'b0;
                    if (cnt_r == CNT_W'(GAP_LEN - 1)) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= {CNT_W{1'b0}};
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                    out_r   <= 1'b0;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_r;
    assign out   = out_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule

// File: tb/tb_sync_frame_tx.sv
// Directed and randomized bench for sync_frame_tx with a bit-stream model and a loopback detector.
module tb_sync_frame_tx;

    localparam int DW  = 8;
    localparam int GAP = 2;

    logic          clk;
    logic          rst;
    logic          start;
    logic [DW-1:0] data;
    logic          ready;
    logic          out;
    logic          busy;
    logic          done;

    int total    = 0;
    int pass_cnt = 0;
    int cyc      = 0;

    bit       det_en  = 1'b0;
    logic [4:0] hist  = 5'b00000;
    int       det_cnt = 0;
    int       det_cyc = -1;

    sync_frame_tx #(.DATA_W(DW), .GAP_LEN(GAP)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .data  (data),
        .ready (ready),
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Independent non-overlapping 11011 detector fed from the serial output.
    always @(negedge clk) begin
        if (det_en) begin
            if ({hist[3:0], out} == 5'b11011) begin
                det_cnt = det_cnt + 1;
                det_cyc = cyc;
                hist    = 5'b00000;
            end else begin
                hist = {hist[3:0], out};
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50 && ready !== 1'b1; i++) tick();
        check("wait_ready", {31'd0, ready}, 32'd1);
    endtask

    // Called one step after the accepting edge; ends in the first IDLE cycle.
    task automatic expect_frame(input logic [DW-1:0] d, input bit poke, input string tag);
        logic [4:0] pre;
        bit         expq[$];
        pre = 5'b11011;
        for (int i = 4; i >= 0; i--) expq.push_back(pre[i]);
        for (int i = DW - 1; i >= 0; i--) expq.push_back(d[i]);
        for (int i = 0; i < GAP; i++) expq.push_back(1'b0);
        for (int i = 0; i < expq.size(); i++) begin
            check({tag, "_out"},   {31'd0, out},   {31'd0, expq[i]});
            check({tag, "_busy"},  {31'd0, busy},  32'd1);
            check({tag, "_ready"}, {31'd0, ready}, 32'd0);
            check({tag, "_done"},  {31'd0, done},  32'd0);
            if (poke && i == 8) begin
                start = 1'b1;
                data  = 8'h3C;
            end else if (poke && i == 9) begin
                start = 1'b0;
            end
            tick();
        end
        check({tag, "_end_done"},  {31'd0, done},  32'd1);
        check({tag, "_end_ready"}, {31'd0, ready}, 32'd1);
        check({tag, "_end_busy"},  {31'd0, busy},  32'd0);
        check({tag, "_end_out"},   {31'd0, out},   32'd0);
    endtask

    function automatic bit has_sync(input logic [DW-1:0] d);
        for (int i = 0; i + 5 <= DW; i++)
            if (((d >> i) & 8'h1F) == 8'h1B) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        int c1;
        int c2;
        int k;
        logic [DW-1:0] d;
        logic [DW-1:0] a5;

        rst   = 1'b0;
        start = 1'b0;
        data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_out",   {31'd0, out},   32'd0);
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_done",  {31'd0, done},  32'd0);
        rst = 1'b1;
        tick();

        // Single A5 frame.
        wait_ready();
        start = 1'b1;
        data  = 8'hA5;
        tick();
        start = 1'b0;
        expect_frame(8'hA5, 1'b0, "single");
        tick();
        check("single_done_low", {31'd0, done},  32'd0);
        check("single_idle_rdy", {31'd0, ready}, 32'd1);

        // Back-to-back with start held high.
        wait_ready();
        start = 1'b1;
        data  = 8'hFF;
        tick();
        c1   = cyc;
        data = 8'h00;
        expect_frame(8'hFF, 1'b0, "b2b_ff");
        tick();
        c2 = cyc;
        check("b2b_period", c2 - c1, 32'd16);
        check("b2b_rdy_gone", {31'd0, ready}, 32'd0);
        start = 1'b0;
        expect_frame(8'h00, 1'b0, "b2b_00");

        // Start and data changes during payload are ignored.
        wait_ready();
        start = 1'b1;
        data  = 8'hA5;
        tick();
        start = 1'b0;
        expect_frame(8'hA5, 1'b1, "ignore");
        for (int i = 0; i < 6; i++) begin
            tick();
            check("ignore_no_busy", {31'd0, busy}, 32'd0);
            check("ignore_no_out",  {31'd0, out},  32'd0);
        end

        // Asynchronous reset during payload bit 3.
        wait_ready();
        a5    = 8'hA5;
        start = 1'b1;
        data  = a5;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("arst_pre_bit", {31'd0, out}, {31'd0, a5[4]});
        check("arst_pre_busy", {31'd0, busy}, 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check("arst_out",   {31'd0, out},   32'd0);
        check("arst_busy",  {31'd0, busy},  32'd0);
        check("arst_ready", {31'd0, ready}, 32'd1);
        check("arst_done",  {31'd0, done},  32'd0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("arst_quiet_out",  {31'd0, out},  32'd0);
            check("arst_quiet_busy", {31'd0, busy}, 32'd0);
        end
        wait_ready();
        start = 1'b1;
        data  = 8'h81;
        tick();
        start = 1'b0;
        expect_frame(8'h81, 1'b0, "after_rst");

        // Loopback of random payloads through the detector.
        tick();
        det_en = 1'b1;
        for (int n = 0; n < 20; n++) begin
            do d = 8'($urandom); while (has_sync(d));
            wait_ready();
            start = 1'b1;
            data  = d;
            tick();
            k     = cyc;
            start = 1'b0;
            expect_frame(d, 1'b0, "loop");
            check("loop_det_cnt", det_cnt, n + 1);
            check("loop_det_cyc", det_cyc, k + 4);
        end
        check("loop_total", det_cnt, 32'd20);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
